// File: rtl/conv_pkg.sv
// Shared convolution-datapath definitions: default pixel/kernel sizes, window
// bit-offset helper and the window generator's state encodings.
package conv_pkg;

    localparam int CONV_DATA_WIDTH  = 8;
    localparam int CONV_KERNEL_SIZE = 3;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } conv_state_e;

    // Bit offset of window element (i,j) in a flattened K*K window.
    function automatic int idx(input int i, input int j,
                               input int k  = CONV_KERNEL_SIZE,
                               input int dw = CONV_DATA_WIDTH);
        return (i * k + j) * dw;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// DEPTH-cycle pixel delay line advanced only on en; DEPTH-1 RAM words plus
// the registered read port make up the full delay.
module conv_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int MEM_DEPTH = DEPTH - 1;
    localparam int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(MEM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [AW-1:0]         ptr_q;
    logic [AW-1:0]         ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Read-before-write on the same word: dout picks up the oldest entry.
    always_ff @(posedge clk) begin
        if (en) begin
            dout_q      <= mem[ptr_q];
            mem[ptr_q]  <= din;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to flattened KxK sliding windows (stride 1, no padding)
// on an AXI-Stream master with a one-deep output register.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = CONV_DATA_WIDTH,
    parameter int KERNEL_SIZE = CONV_KERNEL_SIZE,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      s_tvalid,
    input  logic [DATA_WIDTH-1:0]                     s_tdata,
    input  logic                                      s_tlast,
    output logic                                      s_tready,
    output logic                                      m_tvalid,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] m_tdata,
    output logic                                      m_tlast,
    input  logic                                      m_tready,
    output logic                                      frame_done,
    output logic                                      err_tlast
);

    localparam int K     = KERNEL_SIZE;
    localparam int WIN_W = DATA_WIDTH * K * K;
    localparam int CW    = $clog2((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT) + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] ROW_FILL = CW'(K - 2);
    localparam logic [CW-1:0] EDGE     = CW'(K - 1);

    conv_state_e state_q, state_d;
    logic [CW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic             rdy_en_q, rdy_en_d;
    logic             m_tvalid_q, m_tvalid_d;
    logic [WIN_W-1:0] m_tdata_q, m_tdata_d;
    logic             m_tlast_q, m_tlast_d;
    logic             err_q, err_d;
    logic             frame_done_c;

    logic accept;
    logic m_hs;
    logic at_last;
    logic emit;
    logic load;

    logic [DATA_WIDTH-1:0] tap     [K-1];
    logic [DATA_WIDTH-1:0] col_new [K];
    logic [DATA_WIDTH-1:0] win_q   [K][K];
    logic [DATA_WIDTH-1:0] win_d   [K][K];
    logic [WIN_W-1:0]      win_flat;

    assign s_tready = rdy_en_q && (state_q != S_DRAIN) && (!m_tvalid_q || m_tready);
    assign accept   = s_tvalid && s_tready;
    assign m_hs     = m_tvalid_q && m_tready;
    assign at_last  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign emit     = (row_q >= EDGE) && (col_q >= EDGE);
    assign load     = accept && emit;

    // Cascaded line buffers: tap[0] is the pixel one row up, tap[K-2] is K-1 rows up.
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
        logic [DATA_WIDTH-1:0] lb_din;
        if (gi == 0) begin : g_first
            assign lb_din = s_tdata;
        end else begin : g_casc
            assign lb_din = tap[gi-1];
        end
        conv_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH)
        ) u_lb (
            .clk  (clk),
            .rstn (rstn),
            .en   (accept),
            .din  (lb_din),
            .dout (tap[gi])
        );
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_col
        if (gi == K - 1) begin : g_cur
            assign col_new[gi] = s_tdata;
        end else begin : g_tap
            assign col_new[gi] = tap[K-2-gi];
        end
    end

    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_d[i][j] = win_q[i][j];
            end
        end
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][K-1] = col_new[i];
            end
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_pack_row
        for (genvar gj = 0; gj < K; gj++) begin : g_pack_col
            localparam int OFS = idx(gi, gj, K, DATA_WIDTH);
            assign win_flat[OFS +: DATA_WIDTH] = win_d[gi][gj];
        end
    end

    always_comb begin
        rdy_en_d   = 1'b1;
        row_d      = row_q;
        col_d      = col_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        err_d      = err_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (s_tlast != at_last) begin
                err_d = 1'b1;
            end
        end
        // A freshly loaded window takes priority over retiring the old one.
        if (load) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = win_flat;
            m_tlast_d  = at_last;
        end else if (m_hs) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_done_c = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept && (row_q == ROW_FILL) && (col_q == COL_LAST)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && at_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (m_hs && m_tlast_q) begin
                    state_d      = S_FILL;
                    frame_done_c = 1'b1;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_FILL;
            row_q      <= '0;
            col_q      <= '0;
            rdy_en_q   <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rdy_en_q   <= rdy_en_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            err_q      <= err_d;
        end
    end

    // Window contents never leave the block unqualified, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_q[i][j] <= win_d[i][j];
            end
        end
    end

    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign m_tlast    = m_tlast_q;
    assign frame_done = frame_done_c;
    assign err_tlast  = err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with K=3, 5x5 frames, pixel(r,c)=base+5r+c.
module tb_conv_window_gen;

    localparam int DW  = 8;
    localparam int K   = 3;
    localparam int W   = 5;
    localparam int H   = 5;
    localparam int WIN = DW * K * K;

    logic           clk = 1'b0;
    logic           rstn;
    logic           s_tvalid;
    logic [DW-1:0]  s_tdata;
    logic           s_tlast;
    logic           s_tready;
    logic           m_tvalid;
    logic [WIN-1:0] m_tdata;
    logic           m_tlast;
    logic           m_tready;
    logic           frame_done;
    logic           err_tlast;

    always #5 clk = ~clk;

    conv_window_gen #(
        .DATA_WIDTH  (DW),
        .KERNEL_SIZE (K),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .frame_done (frame_done),
        .err_tlast  (err_tlast)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_win = 0;
    int n_fdone = 0;
    int acc12_cyc = 0;
    int first_hs_cyc = -1;
    int w0, f0;
    bit rand_valid = 1'b0;
    bit rand_rdy   = 1'b0;
    logic           prev_stall = 1'b0;
    logic [WIN-1:0] prev_data  = '0;
    logic [WIN:0]   exp_q [$];

    task automatic chk(input string tag, input logic [WIN-1:0] got, input logic [WIN-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIN-1:0] exp_win(input int base, input int r, input int c);
        logic [WIN-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w[(i*K+j)*DW +: DW] = DW'(base + W*(r-K+1+i) + (c-K+1+j));
            end
        end
        return w;
    endfunction

    task automatic push_windows(input int base, input int n);
        int cnt = 0;
        for (int r = K-1; r < H; r++) begin
            for (int c = K-1; c < W; c++) begin
                if (cnt < n) begin
                    exp_q.push_back({((r == H-1) && (c == W-1)), exp_win(base, r, c)});
                end
                cnt++;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            m_tready = ($urandom_range(0, 1) == 1);
        end
    end

    // Output monitor: scoreboard compare plus stall-stability protocol checks.
    always @(negedge clk) begin
        logic [WIN:0] e;
        if (rstn) begin
            if (prev_stall) begin
                chk("stall_valid", WIN'(m_tvalid), WIN'(1));
                chk("stall_data", m_tdata, prev_data);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_window", WIN'(1), WIN'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("win_data", m_tdata, e[WIN-1:0]);
                    chk("win_last", WIN'(m_tlast), WIN'(e[WIN]));
                    chk("win_fdone", WIN'(frame_done), WIN'(e[WIN]));
                    if (first_hs_cyc < 0) first_hs_cyc = cyc;
                    n_win++;
                    $display("window %0d data=%h last=%0b", n_win, m_tdata, m_tlast);
                end
            end
            if (frame_done) n_fdone++;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic drive_pixel(input int v, input bit last, input int idx);
        int guard = 0;
        bit acc = 1'b0;
        if (rand_valid) begin
            while ($urandom_range(0, 1) == 1) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_tvalid = 1'b1;
        s_tdata  = DW'(v);
        s_tlast  = last;
        while (!acc && guard < 1000) begin
            @(negedge clk);
            acc = s_tready;
            guard++;
        end
        if (!acc) chk("accept_timeout", WIN'(0), WIN'(1));
        if (idx == 12) acc12_cyc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic drive_range(input int base, input int lo, input int hi, input int tl_idx);
        for (int i = lo; i <= hi; i++) begin
            drive_pixel(base + W*(i/W) + (i%W), (i == tl_idx), i);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, WIN'(exp_q.size()), WIN'(0));
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_s_tready"}, WIN'(s_tready), WIN'(0));
        chk({pfx, "_m_tvalid"}, WIN'(m_tvalid), WIN'(0));
        chk({pfx, "_m_tdata"}, m_tdata, WIN'(0));
        chk({pfx, "_m_tlast"}, WIN'(m_tlast), WIN'(0));
        chk({pfx, "_frame_done"}, WIN'(frame_done), WIN'(0));
        chk({pfx, "_err_tlast"}, WIN'(err_tlast), WIN'(0));
    endtask

    initial begin
        rstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks("rst0");
        rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst0_ready_after", WIN'(s_tready), WIN'(1));
        @(posedge clk); #1;

        // 1: continuous stream
        w0 = n_win; f0 = n_fdone;
        push_windows(0, 9);
        drive_range(0, 0, 24, 24);
        wait_drain("t1_drain", 200);
        chk("t1_latency", WIN'(first_hs_cyc - acc12_cyc), WIN'(1));
        chk("t1_nwin", WIN'(n_win - w0), WIN'(9));
        chk("t1_fdone", WIN'(n_fdone - f0), WIN'(1));
        chk("t1_err", WIN'(err_tlast), WIN'(0));

        // 2: four-cycle downstream stall with a window pending
        w0 = n_win;
        push_windows(0, 9);
        drive_range(0, 0, 12, 24);
        m_tready = 1'b0;
        s_tvalid = 1'b1; s_tdata = DW'(13); s_tlast = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_valid", WIN'(m_tvalid), WIN'(1));
            chk("t2_data", m_tdata, exp_win(0, 2, 2));
            chk("t2_s_tready", WIN'(s_tready), WIN'(0));
            @(posedge clk); #1;
        end
        m_tready = 1'b1;
        drive_range(0, 13, 24, 24);
        wait_drain("t2_drain", 200);
        chk("t2_nwin", WIN'(n_win - w0), WIN'(9));

        // 3: back-to-back frames
        w0 = n_win; f0 = n_fdone;
        push_windows(0, 9);
        push_windows(100, 9);
        drive_range(0, 0, 24, 24);
        s_tvalid = 1'b1; s_tdata = DW'(100); s_tlast = 1'b0;
        @(negedge clk);
        chk("t3_drain_ready", WIN'(s_tready), WIN'(0));
        chk("t3_drain_last", WIN'(m_tvalid && m_tlast), WIN'(1));
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("t3_ready_after", WIN'(s_tready), WIN'(1));
        @(posedge clk); #1;
        drive_range(100, 0, 24, 24);
        wait_drain("t3_drain", 300);
        chk("t3_nwin", WIN'(n_win - w0), WIN'(18));
        chk("t3_fdone", WIN'(n_fdone - f0), WIN'(2));

        // 4: reset mid-frame after 17 pixels
        push_windows(0, 3);
        drive_range(0, 0, 16, 24);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_pending", WIN'(exp_q.size()), WIN'(0));
        rstn = 1'b0;
        @(negedge clk);
        reset_checks("t4_rst");
        rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_ready_after", WIN'(s_tready), WIN'(1));
        @(posedge clk); #1;
        w0 = n_win; f0 = n_fdone;
        push_windows(0, 9);
        drive_range(0, 0, 24, 24);
        wait_drain("t4_drain", 200);
        chk("t4_nwin", WIN'(n_win - w0), WIN'(9));
        chk("t4_fdone", WIN'(n_fdone - f0), WIN'(1));
        chk("t4_err", WIN'(err_tlast), WIN'(0));

        // 5: misplaced s_tlast
        w0 = n_win;
        push_windows(0, 9);
        drive_range(0, 0, 19, 20);
        @(negedge clk);
        chk("t5_err_before", WIN'(err_tlast), WIN'(0));
        @(posedge clk); #1;
        drive_range(0, 20, 20, 20);
        @(negedge clk);
        chk("t5_err_rise", WIN'(err_tlast), WIN'(1));
        @(posedge clk); #1;
        drive_range(0, 21, 24, 20);
        wait_drain("t5_drain", 200);
        chk("t5_err_sticky", WIN'(err_tlast), WIN'(1));
        chk("t5_nwin", WIN'(n_win - w0), WIN'(9));

        // 6: random valid/ready over three frames
        w0 = n_win; f0 = n_fdone;
        push_windows(7, 9);
        push_windows(60, 9);
        push_windows(200, 9);
        rand_valid = 1'b1;
        rand_rdy   = 1'b1;
        drive_range(7, 0, 24, 24);
        drive_range(60, 0, 24, 24);
        drive_range(200, 0, 24, 24);
        wait_drain("t6_drain", 3000);
        chk("t6_nwin", WIN'(n_win - w0), WIN'(27));
        chk("t6_fdone", WIN'(n_fdone - f0), WIN'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
